// File: rtl/ps2_scancode_decoder.sv
// PS/2 set-2 scancode decoder: folds E0/F0/E1 prefixes into single key events with a prefix timeout.
// Optional key-down map and query port enabled by defining PS2_DECODER_KEYMAP_EN.
module ps2_scancode_decoder #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       CLOCK_50,
    input  logic       reset_n,
    input  logic [7:0] received_data,
    input  logic       received_data_en,
    output logic       key_event,
    output logic [7:0] key_code,
    output logic       key_extended,
    output logic       key_released,
    output logic       seq_error
`ifdef PS2_DECODER_KEYMAP_EN
    ,
    input  logic [7:0] query_code,
    input  logic       query_ext,
    output logic       query_down
`endif
);

    localparam int TO_W = ($clog2(TIMEOUT_CYCLES) < 1) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_E0    = 3'd1,
        S_F0    = 3'd2,
        S_E0F0  = 3'd3,
        S_PAUSE = 3'd4
    } state_t;

    state_t          r_state;
    logic [2:0]      r_skip;
    logic [TO_W-1:0] r_to_cnt;
    logic            r_key_event;
    logic [7:0]      r_key_code;
    logic            r_key_ext;
    logic            r_key_rel;
    logic            r_seq_error;

    // Controller acknowledge / self-test / error bytes that never start a key sequence.
    function automatic logic is_ignored(input logic [7:0] b);
        case (b)
            8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF: is_ignored = 1'b1;
            default:                                 is_ignored = 1'b0;
        endcase
    endfunction

    // Prefix FSM, skip/timeout counters and registered event outputs.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_skip      <= 3'd0;
            r_to_cnt    <= '0;
            r_key_event <= 1'b0;
            r_key_code  <= 8'h00;
            r_key_ext   <= 1'b0;
            r_key_rel   <= 1'b0;
            r_seq_error <= 1'b0;
        end else begin
            r_key_event <= 1'b0;
            r_seq_error <= 1'b0;
            if (received_data_en) begin
                r_to_cnt <= '0;
                case (r_state)
                    S_IDLE: begin
                        if (received_data == 8'hE0) begin
                            r_state <= S_E0;
                        end else if (received_data == 8'hF0) begin
                            r_state <= S_F0;
                        end else if (received_data == 8'hE1) begin
                            r_state <= S_PAUSE;
                            r_skip  <= 3'd7;
                        end else if (is_ignored(received_data)) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_key_event <= 1'b1;
                            r_key_code  <= received_data;
                            r_key_ext   <= 1'b0;
                            r_key_rel   <= 1'b0;
                        end
                    end
                    S_E0: begin
                        if (received_data == 8'hF0) begin
                            r_state <= S_E0F0;
                        end else if (received_data == 8'hE0) begin
                            r_state <= S_E0;
                        end else begin
                            r_state     <= S_IDLE;
                            r_key_event <= 1'b1;
                            r_key_code  <= received_data;
                            r_key_ext   <= 1'b1;
                            r_key_rel   <= 1'b0;
                        end
                    end
                    S_F0: begin
                        r_state     <= S_IDLE;
                        r_key_event <= 1'b1;
                        r_key_code  <= received_data;
                        r_key_ext   <= 1'b0;
                        r_key_rel   <= 1'b1;
                    end
                    S_E0F0: begin
                        r_state     <= S_IDLE;
                        r_key_event <= 1'b1;
                        r_key_code  <= received_data;
                        r_key_ext   <= 1'b1;
                        r_key_rel   <= 1'b1;
                    end
                    S_PAUSE: begin
                        // Pause has no break code: its whole 8-byte burst collapses to one make.
                        if (r_skip <= 3'd1) begin
                            r_state     <= S_IDLE;
                            r_skip      <= 3'd0;
                            r_key_event <= 1'b1;
                            r_key_code  <= 8'hE1;
                            r_key_ext   <= 1'b0;
                            r_key_rel   <= 1'b0;
                        end else begin
                            r_skip <= r_skip - 3'd1;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_skip  <= 3'd0;
                    end
                endcase
            end else if (r_state != S_IDLE) begin
                if (r_to_cnt == TO_MAX) begin
                    r_state     <= S_IDLE;
                    r_skip      <= 3'd0;
                    r_to_cnt    <= '0;
                    r_seq_error <= 1'b1;
                end else begin
                    r_to_cnt <= r_to_cnt + {{(TO_W-1){1'b0}}, 1'b1};
                end
            end else begin
                r_to_cnt <= '0;
            end
        end
    end

    assign key_event    = r_key_event;
    assign key_code     = r_key_code;
    assign key_extended = r_key_ext;
    assign key_released = r_key_rel;
    assign seq_error    = r_seq_error;

`ifdef PS2_DECODER_KEYMAP_EN
    logic [511:0] r_keymap;
    logic [8:0]   w_query_idx;

    // Key-down map follows the registered event one cycle later.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_keymap <= '0;
        end else if (r_key_event) begin
            r_keymap[{r_key_ext, r_key_code}] <= ~r_key_rel;
        end else begin
            r_keymap <= r_keymap;
        end
    end

    assign w_query_idx = {query_ext, query_code};
    assign query_down  = r_keymap[w_query_idx];
`endif

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Self-checking bench for ps2_scancode_decoder: vector table plus scoreboard of expected key events.
module tb_ps2_scancode_decoder;

    localparam int TO_MAIN  = 50000;
    localparam int TO_SMALL = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] data;
    logic       en;

    logic       key_event, key_ext, key_rel, seq_err;
    logic [7:0] key_code;
    logic       s_key_event, s_key_ext, s_key_rel, s_seq_err;
    logic [7:0] s_key_code;
`ifdef PS2_DECODER_KEYMAP_EN
    logic [7:0] q_code;
    logic       q_ext, q_down, s_q_down;
`endif

    always #5 clk = ~clk;

    ps2_scancode_decoder #(.TIMEOUT_CYCLES(TO_MAIN)) dut (
        .CLOCK_50(clk), .reset_n(rst_n), .received_data(data), .received_data_en(en),
        .key_event(key_event), .key_code(key_code), .key_extended(key_ext),
        .key_released(key_rel), .seq_error(seq_err)
`ifdef PS2_DECODER_KEYMAP_EN
        , .query_code(q_code), .query_ext(q_ext), .query_down(q_down)
`endif
    );

    ps2_scancode_decoder #(.TIMEOUT_CYCLES(TO_SMALL)) dut_s (
        .CLOCK_50(clk), .reset_n(rst_n), .received_data(data), .received_data_en(en),
        .key_event(s_key_event), .key_code(s_key_code), .key_extended(s_key_ext),
        .key_released(s_key_rel), .seq_error(s_seq_err)
`ifdef PS2_DECODER_KEYMAP_EN
        , .query_code(q_code), .query_ext(q_ext), .query_down(s_q_down)
`endif
    );

    typedef struct {
        int          n;
        logic [63:0] bytes;   // first byte in bits 63:56
        int          evt;     // index of completing byte, -1 for none
        logic [7:0]  code;
        logic        ext;
        logic        rel;
    } vec_t;

    typedef struct {
        logic [7:0] code;
        logic       ext;
        logic       rel;
        longint     cyc;
    } exp_t;

    int         checks   = 0;
    int         failures = 0;
    longint     cyc      = 0;
    longint     exp_seq_cyc = -1;
    bit         seq_seen = 1'b0;
    exp_t       sbq[$];
    logic [7:0] last_code = 8'h00;
    logic       last_ext  = 1'b0;
    logic       last_rel  = 1'b0;
    vec_t       vecs[10];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Scoreboard consumer: every key_event / seq_error pulse must be expected, in the right cycle.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (key_event) begin
                checks++;
                if (sbq.size() == 0) begin
                    failures++;
                    $display("FAIL evt_unexpected actual code=%h ext=%b rel=%b cyc=%0d expected none",
                             key_code, key_ext, key_rel, cyc);
                end else begin
                    e = sbq.pop_front();
                    if (key_code !== e.code || key_ext !== e.ext || key_rel !== e.rel || cyc != e.cyc) begin
                        failures++;
                        $display("FAIL evt actual code=%h ext=%b rel=%b cyc=%0d expected code=%h ext=%b rel=%b cyc=%0d",
                                 key_code, key_ext, key_rel, cyc, e.code, e.ext, e.rel, e.cyc);
                    end
                end
            end
            if (seq_err) begin
                checks++;
                if (cyc != exp_seq_cyc) begin
                    failures++;
                    $display("FAIL seq_error actual_cyc=%0d expected_cyc=%0d", cyc, exp_seq_cyc);
                end
                seq_seen    = 1'b1;
                exp_seq_cyc = -1;
            end
        end
    end

    task automatic send(input logic [7:0] b, input bit expect_evt,
                        input logic [7:0] c, input logic x, input logic r);
        exp_t e;
        @(negedge clk);
        data = b;
        en   = 1'b1;
        if (expect_evt) begin
            e.code = c; e.ext = x; e.rel = r; e.cyc = cyc + 1;
            sbq.push_back(e);
            last_code = c; last_ext = x; last_rel = r;
        end
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        en = 1'b0;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_drain"}, sbq.size(), 0);
        chk({tag, "_code"}, {24'h0, key_code}, {24'h0, last_code});
        chk({tag, "_flags"}, {30'h0, key_ext, key_rel}, {30'h0, last_ext, last_rel});
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_evt"}, {31'h0, key_event}, 32'h0);
        chk({tag, "_code"}, {24'h0, key_code}, 32'h0);
        chk({tag, "_flags"}, {29'h0, key_ext, key_rel, seq_err}, 32'h0);
`ifdef PS2_DECODER_KEYMAP_EN
        chk({tag, "_qdown"}, {31'h0, q_down}, 32'h0);
`endif
    endtask

    initial begin
        longint c0;
        rst_n = 1'b0; data = 8'h00; en = 1'b0;
`ifdef PS2_DECODER_KEYMAP_EN
        q_code = 8'h75; q_ext = 1'b1;
`endif
        vecs[0] = '{1, 64'h1C00_0000_0000_0000,  0, 8'h1C, 1'b0, 1'b0};
        vecs[1] = '{2, 64'hF01C_0000_0000_0000,  1, 8'h1C, 1'b0, 1'b1};
        vecs[2] = '{3, 64'hE0F0_7500_0000_0000,  2, 8'h75, 1'b1, 1'b1};
        vecs[3] = '{8, 64'hE114_77E1_F014_F077,  7, 8'hE1, 1'b0, 1'b0};
        vecs[4] = '{1, 64'hFA00_0000_0000_0000, -1, 8'h00, 1'b0, 1'b0};
        vecs[5] = '{1, 64'hAA00_0000_0000_0000, -1, 8'h00, 1'b0, 1'b0};
        vecs[6] = '{2, 64'hE075_0000_0000_0000,  1, 8'h75, 1'b1, 1'b0};
        vecs[7] = '{3, 64'hE0E0_6B00_0000_0000,  2, 8'h6B, 1'b1, 1'b0};
        vecs[8] = '{5, 64'h00EE_FEFF_2900_0000,  4, 8'h29, 1'b0, 1'b0};
        vecs[9] = '{2, 64'hF0E0_0000_0000_0000,  1, 8'hE0, 1'b0, 1'b1};

        repeat (3) @(negedge clk);
        check_reset_outputs("reset_init");
        rst_n = 1'b1;
        idle(2);

        for (int v = 0; v < 10; v++) begin
            for (int i = 0; i < vecs[v].n; i++) begin
                send(vecs[v].bytes[63 - 8*i -: 8], (i == vecs[v].evt),
                     vecs[v].code, vecs[v].ext, vecs[v].rel);
            end
            idle(4);
            check_quiet($sformatf("vec%0d", v));
        end

`ifdef PS2_DECODER_KEYMAP_EN
        send(8'hE0, 1'b0, 8'h00, 1'b0, 1'b0);
        send(8'h75, 1'b1, 8'h75, 1'b1, 1'b0);
        idle(3);
        q_code = 8'h75; q_ext = 1'b1; #1;
        chk("map_ext75_down", {31'h0, q_down}, 32'h1);
        q_ext = 1'b0; #1;
        chk("map_base75_up", {31'h0, q_down}, 32'h0);
        send(8'hE0, 1'b0, 8'h00, 1'b0, 1'b0);
        send(8'hF0, 1'b0, 8'h00, 1'b0, 1'b0);
        send(8'h75, 1'b1, 8'h75, 1'b1, 1'b1);
        idle(3);
        q_ext = 1'b1; #1;
        chk("map_ext75_released", {31'h0, q_down}, 32'h0);
`endif

        // Short-timeout instance: abandon on exact cycle, then byte wins on the timeout cycle.
        send(8'hE0, 1'b0, 8'h00, 1'b0, 1'b0);
        c0 = cyc;
        idle(TO_SMALL);
        @(negedge clk);
        chk("small_timeout_cyc", {31'h0, s_seq_err}, 32'h1);
        send(8'h75, 1'b1, 8'h75, 1'b1, 1'b0);
        idle(4);
        check_quiet("after_small_to");
        send(8'hE0, 1'b0, 8'h00, 1'b0, 1'b0);
        idle(TO_SMALL - 1);
        send(8'h75, 1'b1, 8'h75, 1'b1, 1'b0);
        @(negedge clk);
        en = 1'b0;
        chk("byte_wins_evt", {23'h0, s_key_event, s_key_code}, {23'h0, 1'b1, 8'h75});
        chk("byte_wins_flags", {30'h0, s_key_ext, s_key_rel}, {30'h0, 1'b1, 1'b0});
        chk("byte_wins_noerr", {31'h0, s_seq_err}, 32'h0);
        @(negedge clk);
        chk("byte_wins_noerr2", {31'h0, s_seq_err}, 32'h0);
        idle(3);
        check_quiet("after_byte_wins");

        // Main instance prefix timeout at its default length.
        send(8'hE0, 1'b0, 8'h00, 1'b0, 1'b0);
        exp_seq_cyc = cyc + 1 + TO_MAIN;
        seq_seen    = 1'b0;
        idle(1);
        for (int k = 0; k < TO_MAIN + 100 && !seq_seen; k++) @(negedge clk);
        chk("timeout_seen", {31'h0, seq_seen}, 32'h1);
        exp_seq_cyc = -1;
        send(8'h1C, 1'b1, 8'h1C, 1'b0, 1'b0);
        idle(4);
        check_quiet("after_timeout");

        // Reset in the middle of a break prefix.
        send(8'hF0, 1'b0, 8'h00, 1'b0, 1'b0);
        idle(1);
        rst_n = 1'b0; #1;
        check_reset_outputs("reset_mid");
        @(negedge clk); @(negedge clk);
        check_reset_outputs("reset_hold");
        rst_n = 1'b1;
        last_code = 8'h00; last_ext = 1'b0; last_rel = 1'b0;
        send(8'h1C, 1'b1, 8'h1C, 1'b0, 1'b0);
        idle(4);
        check_quiet("after_reset");

        chk("final_drain", sbq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
